// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline stage register with flush, bubble control-zeroing
// and an optional skid entry that makes in_ready a pure register output.
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic              w_out_valid_nxt;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic [CTRL_W-1:0] w_out_ctrl_nxt;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;

  logic w_in_ready;
  logic w_acc;
  logic w_main_free;

  // With a skid entry in_ready depends only on state, cutting the out_ready path.
  assign w_in_ready  = (SKID != 0) ? ~r_skid_valid : (out_ready | ~r_out_valid);
  assign w_acc       = in_valid & w_in_ready;
  assign w_main_free = ~r_out_valid | out_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_out_ctrl_nxt   = r_out_ctrl;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_ctrl_nxt  = r_skid_ctrl;

    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_out_ctrl_nxt   = '0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // The skid entry is older than anything arriving now, so it goes first.
        w_out_valid_nxt  = 1'b1;
        w_out_data_nxt   = r_skid_data;
        w_out_ctrl_nxt   = r_skid_ctrl;
        w_skid_valid_nxt = w_acc;
        if (w_acc) begin
          w_skid_data_nxt = in_data;
          w_skid_ctrl_nxt = in_ctrl;
        end
      end else if (w_acc) begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = in_data;
        w_out_ctrl_nxt  = in_ctrl;
      end else begin
        w_out_valid_nxt = 1'b0;
        w_out_ctrl_nxt  = '0;
      end
    end else if (w_acc) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_data_nxt  = in_data;
      w_skid_ctrl_nxt  = in_ctrl;
    end
  end

  // NOTE: payload registers are reset as well as the valid flags, so out_data
  // comes out of reset as a defined zero rather than whatever the flops held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ctrl   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so all state updates see the
      // pre-edge values, independent of statement order.
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_ctrl   <= w_out_ctrl_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_ctrl  <= w_skid_ctrl_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ctrl  = r_out_ctrl;
  assign occupancy = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed vector table on the SKID=1 build plus hand sequences for reset, and a
// random scoreboard run on a SKID=0 build.
module tb_pipe_stage_hs;

  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // SKID=1 instance
  logic          iv, ir, fl, ov, ordy;
  logic [DW-1:0] idata, odata;
  logic [CW-1:0] ictrl, octrl;
  logic [1:0]    occ;

  // SKID=0 instance
  logic          s_iv, s_ir, s_fl, s_ov, s_ordy;
  logic [DW-1:0] s_idata, s_odata;
  logic [CW-1:0] s_ictrl, s_octrl;
  logic [1:0]    s_occ;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(idata),
    .in_ctrl(ictrl), .flush(fl), .out_valid(ov), .out_ready(ordy),
    .out_data(odata), .out_ctrl(octrl), .occupancy(occ)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_idata),
    .in_ctrl(s_ictrl), .flush(s_fl), .out_valid(s_ov), .out_ready(s_ordy),
    .out_data(s_odata), .out_ctrl(s_octrl), .occupancy(s_occ)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          fl;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_d;
    logic [CW-1:0] e_c;
    logic          e_rdy;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v_iv, logic [DW-1:0] v_d, logic [CW-1:0] v_c,
                              logic v_fl, logic v_ordy, logic e_ov, logic [DW-1:0] e_d,
                              logic [CW-1:0] e_c, logic e_rdy, logic [1:0] e_occ);
    vec_t v;
    v.iv = v_iv; v.d = v_d; v.c = v_c; v.fl = v_fl; v.ordy = v_ordy;
    v.e_ov = e_ov; v.e_d = e_d; v.e_c = e_c; v.e_rdy = e_rdy; v.e_occ = e_occ;
    return v;
  endfunction

  logic [DW+CW-1:0] sb[$];

  // One cycle of the SKID=0 instance: drive, settle, check, track handshakes.
  task automatic sk0_step(input logic v_iv, input logic v_ordy);
    logic [DW+CW-1:0] exp;
    @(negedge clk);
    s_iv    = v_iv;
    s_ordy  = v_ordy;
    s_idata = $urandom;
    s_ictrl = CW'($urandom_range(1, 255));
    #1;
    check("sk0_in_ready", {63'd0, s_ir}, {63'd0, s_ordy | ~s_ov});
    check("sk0_occ", {62'd0, s_occ}, {63'd0, s_ov});
    if (!s_ov) check("sk0_bubble_ctrl", {56'd0, s_octrl}, 64'd0);
    if (s_ov && s_ordy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sk0_dup: got 0x%0h expected no output", s_odata);
      end else begin
        exp = sb.pop_front();
        check("sk0_order", {24'd0, s_octrl, s_odata}, {24'd0, exp});
      end
    end
    if (s_iv && s_ir) sb.push_back({s_ictrl, s_idata});
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    iv = 0; idata = '0; ictrl = '0; fl = 0; ordy = 0;
    s_iv = 0; s_idata = '0; s_ictrl = '0; s_fl = 0; s_ordy = 0;

    // streaming, bubbles, stall with skid, flush with and without an accept
    vecs.push_back(mk(1, 32'h100, 8'h01, 0, 1,  1, 32'h100, 8'h01, 1, 1));
    vecs.push_back(mk(1, 32'h104, 8'h02, 0, 1,  1, 32'h104, 8'h02, 1, 1));
    vecs.push_back(mk(1, 32'h108, 8'h03, 0, 1,  1, 32'h108, 8'h03, 1, 1));
    vecs.push_back(mk(0, 32'h0,   8'h00, 0, 1,  0, 32'h108, 8'h00, 1, 0));
    vecs.push_back(mk(1, 32'h200, 8'hFF, 0, 1,  1, 32'h200, 8'hFF, 1, 1));
    vecs.push_back(mk(0, 32'h0,   8'h00, 0, 1,  0, 32'h200, 8'h00, 1, 0));
    vecs.push_back(mk(1, 32'h201, 8'hFF, 0, 1,  1, 32'h201, 8'hFF, 1, 1));
    vecs.push_back(mk(0, 32'h0,   8'h00, 0, 1,  0, 32'h201, 8'h00, 1, 0));
    vecs.push_back(mk(1, 32'hA,   8'h11, 0, 0,  1, 32'hA,   8'h11, 1, 1));
    vecs.push_back(mk(1, 32'hB,   8'h12, 0, 0,  1, 32'hA,   8'h11, 0, 2));
    vecs.push_back(mk(1, 32'hC,   8'h13, 0, 0,  1, 32'hA,   8'h11, 0, 2));
    vecs.push_back(mk(1, 32'hC,   8'h13, 0, 1,  1, 32'hB,   8'h12, 1, 1));
    vecs.push_back(mk(1, 32'hC,   8'h13, 0, 1,  1, 32'hC,   8'h13, 1, 1));
    vecs.push_back(mk(0, 32'h0,   8'h00, 0, 1,  0, 32'hC,   8'h00, 1, 0));
    vecs.push_back(mk(1, 32'hD0,  8'h21, 0, 0,  1, 32'hD0,  8'h21, 1, 1));
    vecs.push_back(mk(1, 32'hD1,  8'h22, 0, 0,  1, 32'hD0,  8'h21, 0, 2));
    vecs.push_back(mk(1, 32'hDEAD,8'h33, 1, 0,  0, 32'hD0,  8'h00, 1, 0));
    vecs.push_back(mk(0, 32'h0,   8'h00, 0, 1,  0, 32'hD0,  8'h00, 1, 0));
    vecs.push_back(mk(1, 32'hE0,  8'h44, 0, 0,  1, 32'hE0,  8'h44, 1, 1));
    vecs.push_back(mk(1, 32'hDEAD,8'h55, 1, 0,  0, 32'hE0,  8'h00, 1, 0));
    vecs.push_back(mk(0, 32'h0,   8'h00, 0, 1,  0, 32'hE0,  8'h00, 1, 0));
    vecs.push_back(mk(1, 32'hF0,  8'h66, 0, 1,  1, 32'hF0,  8'h66, 1, 1));
    vecs.push_back(mk(0, 32'h0,   8'h00, 1, 1,  0, 32'hF0,  8'h00, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, ov}, 64'd0);
    check("rst_out_data",  {32'd0, odata}, 64'd0);
    check("rst_out_ctrl",  {56'd0, octrl}, 64'd0);
    check("rst_occ",       {62'd0, occ}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      iv = vecs[i].iv; idata = vecs[i].d; ictrl = vecs[i].c;
      fl = vecs[i].fl; ordy = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), {63'd0, ov}, {63'd0, vecs[i].e_ov});
      check($sformatf("v%0d_out_data", i),  {32'd0, odata}, {32'd0, vecs[i].e_d});
      check($sformatf("v%0d_out_ctrl", i),  {56'd0, octrl}, {56'd0, vecs[i].e_c});
      check($sformatf("v%0d_in_ready", i),  {63'd0, ir}, {63'd0, vecs[i].e_rdy});
      check($sformatf("v%0d_occ", i),       {62'd0, occ}, {62'd0, vecs[i].e_occ});
    end

    // asynchronous reset with two entries held
    @(negedge clk);
    iv = 1; idata = 32'h300; ictrl = 8'h77; fl = 0; ordy = 0;
    @(negedge clk);
    idata = 32'h301; ictrl = 8'h78;
    @(posedge clk);
    #1;
    check("pre_rst_occ", {62'd0, occ}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {63'd0, ov}, 64'd0);
    check("async_rst_out_ctrl",  {56'd0, octrl}, 64'd0);
    check("async_rst_occ",       {62'd0, occ}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    iv = 0; ordy = 1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready",  {63'd0, ir}, 64'd1);
    check("post_rst_out_valid", {63'd0, ov}, 64'd0);

    // SKID=0 random traffic against a FIFO scoreboard
    for (int cyc = 0; cyc < 10000; cyc++)
      sk0_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int cyc = 0; cyc < 3; cyc++)
      sk0_step(1'b0, 1'b1);
    check("sk0_sb_empty", 64'(sb.size()), 64'd0);
    check("sk0_final_out_valid", {63'd0, s_ov}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
